// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RELEASE,
        RUN,
        HOLD
    } state_t;

    localparam logic [7:0] LOCK_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == LOCK_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control and status bundle between the reset sequencer and its environment.
interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
);
    logic                  lock;
    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] stage_reset_n;
    logic                  seq_done;
    logic                  soft_reset_ack;
    logic [7:0]            lock_loss_cnt;

    modport master (
        input  lock,
        input  soft_reset_req,
        output stage_reset_n,
        output seq_done,
        output soft_reset_ack,
        output lock_loss_cnt
    );

    modport slave (
        output lock,
        output soft_reset_req,
        input  stage_reset_n,
        input  seq_done,
        input  soft_reset_ack,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/rst_seq_timer.sv
// Delay counter shared by lock qualification, inter-stage gap and soft-reset hold.
module rst_seq_timer #(
    parameter int unsigned DELAY_CYCLES = 16,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DELAY_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies PLL lock, then releases NUM_STAGES domain resets in ascending order with fixed gaps.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 4,
    parameter int unsigned DELAY_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    reset_sequencer_if.master   bus
);
    localparam int unsigned CNT_W = $clog2(DELAY_CYCLES);
    localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;
    logic [7:0]            loss_q, loss_d;
    logic                  tmr_clr, tmr_en, tmr_tc;

    rst_seq_timer #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .tc      (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        loss_d  = loss_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        unique case (state_q)
            WAIT_LOCK: begin
                stage_d = '0;
                if (!bus.lock) begin
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_d = RELEASE;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RELEASE: begin
                if (!bus.lock) begin
                    stage_d = '0;
                    loss_d  = sat_inc(loss_q);
                    state_d = WAIT_LOCK;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    stage_d[idx_q] = 1'b1;
                    tmr_clr        = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RUN: begin
                // Lock loss takes priority over a coincident soft request.
                if (!bus.lock) begin
                    stage_d = '0;
                    loss_d  = sat_inc(loss_q);
                    state_d = WAIT_LOCK;
                    tmr_clr = 1'b1;
                end else if (bus.soft_reset_req) begin
                    stage_d = '0;
                    state_d = HOLD;
                    tmr_clr = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            HOLD: begin
                // Lock is ignored here; WAIT_LOCK requalifies it afterwards.
                stage_d = '0;
                if (tmr_tc) begin
                    ack_d   = 1'b1;
                    state_d = WAIT_LOCK;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                stage_d = '0;
                state_d = WAIT_LOCK;
                tmr_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            loss_q  <= loss_d;
        end
    end

    assign bus.stage_reset_n  = stage_q;
    assign bus.seq_done       = done_q;
    assign bus.soft_reset_ack = ack_q;
    assign bus.lock_loss_cnt  = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_STAGES=4, DELAY_CYCLES=16.
module tb_reset_sequencer;

    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   cyc;

    reset_sequencer_if #(.NUM_STAGES(4)) bus ();

    reset_sequencer #(
        .NUM_STAGES   (4),
        .DELAY_CYCLES (16)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one posedge, then settle 1 time unit before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        bus.lock = 1'b1;
        bus.soft_reset_req = 1'b0;

        // 1. Power-up sequence with lock held high
        repeat (5) tick();
        check("rst_stage", 32'(bus.stage_reset_n), 32'h0);
        check("rst_done", 32'(bus.seq_done), 32'h0);
        check("rst_ack", 32'(bus.soft_reset_ack), 32'h0);
        check("rst_loss", 32'(bus.lock_loss_cnt), 32'h0);
        reset_n = 1'b1;
        cyc = 0;
        wait_to(31);
        check("t1_stage_31", 32'(bus.stage_reset_n), 32'h0);
        tick();
        check("t1_stage_32", 32'(bus.stage_reset_n), 32'h1);
        // Soft request during RELEASE must be ignored
        wait_to(39);
        bus.soft_reset_req = 1'b1;
        tick();
        bus.soft_reset_req = 1'b0;
        check("t1_softrel_stage", 32'(bus.stage_reset_n), 32'h1);
        wait_to(47);
        check("t1_stage_47", 32'(bus.stage_reset_n), 32'h1);
        tick();
        check("t1_stage_48", 32'(bus.stage_reset_n), 32'h3);
        wait_to(64);
        check("t1_stage_64", 32'(bus.stage_reset_n), 32'h7);
        wait_to(79);
        check("t1_stage_79", 32'(bus.stage_reset_n), 32'h7);
        tick();
        check("t1_stage_80", 32'(bus.stage_reset_n), 32'hF);
        check("t1_done_80", 32'(bus.seq_done), 32'h0);
        tick();
        check("t1_done_81", 32'(bus.seq_done), 32'h1);
        check("t1_loss", 32'(bus.lock_loss_cnt), 32'h0);
        check("t1_ack", 32'(bus.soft_reset_ack), 32'h0);

        // 3. One-cycle lock loss in RUN
        wait_to(90);
        bus.lock = 1'b0;
        tick();
        bus.lock = 1'b1;
        check("t3_stage", 32'(bus.stage_reset_n), 32'h0);
        check("t3_done", 32'(bus.seq_done), 32'h0);
        check("t3_loss", 32'(bus.lock_loss_cnt), 32'h1);
        wait_to(122);
        check("t3_stage_122", 32'(bus.stage_reset_n), 32'h0);
        tick();
        check("t3_stage_123", 32'(bus.stage_reset_n), 32'h1);
        wait_to(170);
        check("t3_stage_170", 32'(bus.stage_reset_n), 32'h7);
        tick();
        check("t3_stage_171", 32'(bus.stage_reset_n), 32'hF);
        check("t3_done_171", 32'(bus.seq_done), 32'h0);
        tick();
        check("t3_done_172", 32'(bus.seq_done), 32'h1);

        // 4. Soft reset in RUN, with a lock glitch during HOLD
        wait_to(180);
        bus.soft_reset_req = 1'b1;
        tick();
        bus.soft_reset_req = 1'b0;
        check("t4_stage", 32'(bus.stage_reset_n), 32'h0);
        check("t4_done", 32'(bus.seq_done), 32'h0);
        wait_to(185);
        bus.lock = 1'b0;
        tick();
        bus.lock = 1'b1;
        check("t4_hold_loss", 32'(bus.lock_loss_cnt), 32'h1);
        wait_to(196);
        check("t4_ack_196", 32'(bus.soft_reset_ack), 32'h0);
        tick();
        check("t4_ack_197", 32'(bus.soft_reset_ack), 32'h1);
        tick();
        check("t4_ack_198", 32'(bus.soft_reset_ack), 32'h0);
        wait_to(228);
        check("t4_stage_228", 32'(bus.stage_reset_n), 32'h0);
        tick();
        check("t4_stage_229", 32'(bus.stage_reset_n), 32'h1);
        wait_to(277);
        check("t4_stage_277", 32'(bus.stage_reset_n), 32'hF);
        check("t4_done_277", 32'(bus.seq_done), 32'h0);
        tick();
        check("t4_done_278", 32'(bus.seq_done), 32'h1);
        check("t4_loss", 32'(bus.lock_loss_cnt), 32'h1);

        // 5. Lock loss and soft request together in RUN
        wait_to(290);
        bus.lock = 1'b0;
        bus.soft_reset_req = 1'b1;
        tick();
        bus.lock = 1'b1;
        bus.soft_reset_req = 1'b0;
        check("t5_stage", 32'(bus.stage_reset_n), 32'h0);
        check("t5_done", 32'(bus.seq_done), 32'h0);
        check("t5_loss", 32'(bus.lock_loss_cnt), 32'h2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_no_ack", 32'(bus.soft_reset_ack), 32'h0);
        end
        wait_to(322);
        check("t5_stage_322", 32'(bus.stage_reset_n), 32'h0);
        tick();
        check("t5_stage_323", 32'(bus.stage_reset_n), 32'h1);

        // 2. Lock glitch in WAIT_LOCK restarts qualification; then lock loss mid-RELEASE
        do_reset(2);
        wait_to(10);
        bus.lock = 1'b0;
        tick();
        bus.lock = 1'b1;
        wait_to(42);
        check("t2_stage_42", 32'(bus.stage_reset_n), 32'h0);
        tick();
        check("t2_stage_43", 32'(bus.stage_reset_n), 32'h1);
        check("t2_loss", 32'(bus.lock_loss_cnt), 32'h0);
        wait_to(64);
        check("t2_stage_64", 32'(bus.stage_reset_n), 32'h3);
        bus.lock = 1'b0;
        tick();
        bus.lock = 1'b1;
        check("t2_relloss_stage", 32'(bus.stage_reset_n), 32'h0);
        check("t2_relloss_cnt", 32'(bus.lock_loss_cnt), 32'h1);

        // 6. Saturation over 300 lock losses, then reset mid-RELEASE
        do_reset(3);
        for (int e = 1; e <= 300; e++) begin
            bus.lock = 1'b1;
            repeat (16) tick();
            bus.lock = 1'b0;
            tick();
            if (e == 1 || e == 254 || e == 255 || e == 300) begin
                check("t6_loss", 32'(bus.lock_loss_cnt), (e > 255) ? 32'd255 : 32'(e));
            end
        end
        check("t6_stage", 32'(bus.stage_reset_n), 32'h0);
        bus.lock = 1'b1;
        cyc = 0;
        wait_to(50);
        check("t6_pre_stage", 32'(bus.stage_reset_n), 32'h3);
        reset_n = 1'b0;
        tick();
        check("t6_rst_stage", 32'(bus.stage_reset_n), 32'h0);
        check("t6_rst_done", 32'(bus.seq_done), 32'h0);
        check("t6_rst_ack", 32'(bus.soft_reset_ack), 32'h0);
        check("t6_rst_loss", 32'(bus.lock_loss_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
